imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the single-cycle core's instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word-aligned byte addresses from 0, then checks an XOR checksum.
- Holds the core in reset until a load completes with a good checksum.

Parameters:
ADDR_W, 8, byte-address width of instruction memory (matches PC byte addressing)
MAX_WORDS, 64, maximum words per load; equals 2^ADDR_W/4

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
byte_in  input  8  stream byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte; transfer when byte_valid && byte_ready
reload  input  1  single-cycle pulse; restarts a load from DONE or ERR
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDR_W  byte address of write, always word aligned (low 2 bits 0)
wr_data  output  32  word to write
cpu_hold  output  1  1 = keep core in reset
done  output  1  load finished, checksum good
error  output  1  load aborted (bad header or checksum)

Behaviour:
- Reset (reset=0, async): state=HEADER; byte_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0; word counter, byte counter and checksum cleared.
- Frame format: header byte N, then 4*N data bytes (MSB first per word), then 1 checksum byte.
  - Header N=0 means MAX_WORDS.
  - Checksum = XOR of header byte and all data bytes.
- HEADER: byte_ready=1.
  - On transfer: checksum=byte_in.
  - N>MAX_WORDS -> ERR.
  - Otherwise store word count (N=0 -> MAX_WORDS) -> DATA.
- DATA: byte_ready=1. Each transfer:
  - Shift byte into word assembly register (first byte -> bits 31:24).
  - XOR byte into checksum.
  - Increment byte counter mod 4.
- Word write on the 4th byte of a word:
  - Next cycle: wr_en=1 for exactly one cycle, wr_data=assembled word, wr_addr=word_index*4.
  - Then increment word_index.
  - byte_ready stays 1 during the write cycle; a byte accepted then belongs to the next word.
- Last word: its 4th byte moves the FSM to CSUM in the same edge; that word's write still occurs in the following cycle.
- CSUM: byte_ready=1.
  - On transfer, byte_in==checksum -> DONE, else ERR.
  - No write occurs in CSUM except the pending last-word write.
- DONE: byte_ready=0, cpu_hold=0, done=1. wr_addr/wr_data hold their last values.
- ERR: byte_ready=0, cpu_hold=1, error=1.
  - Words already written stay in memory; the core is not released.
- reload in DONE or ERR:
  - Next state HEADER; cpu_hold=1, done=0, error=0.
  - Counters and checksum cleared.
  - reload is ignored in HEADER, DATA and CSUM.
- No transfer when byte_valid=0: state and counters hold. byte_valid gaps of any length are legal mid-word.
- Address wrap cannot occur: word_index max is MAX_WORDS-1, so wr_addr max is 2^ADDR_W-4.
- Async reset mid-load: immediately returns to reset values. Memory contents are not cleared; cpu_hold=1 protects the core.
- Outputs byte_ready, wr_*, cpu_hold, done, error are registered (no combinational path from byte_valid/byte_in).

Test Plan:
- Frame N=1, bytes 20 08 00 05 → wr_en one cycle with wr_addr=0x00, wr_data=0x20080005. Checksum 01^20^08^00^05=0x2C → done=1, cpu_hold=0, byte_ready=0.
- Frame N=2 with byte_valid toggled every other cycle → two writes at 0x00 and 0x04 with correct data; no extra wr_en pulses.
- Header 0x41 (65) → error=1, cpu_hold=1, no wr_en ever asserted.
- N=1 frame with checksum 0x2D → word written at 0x00, then error=1, done=0, cpu_hold=1. Then reload pulse → state HEADER, error=0, byte_ready=1.
- Header 0x00, 256 data bytes, continuous valid, correct checksum → 64 writes, last at wr_addr=0xFC; done=1.
- Assert reset=0 after 6 data bytes of N=2 → all outputs immediately at reset values. New N=1 frame then loads to 0x00 correctly.

Source files
------------

// File: rtl/imem_loader_if.sv
// Purpose : byte-stream ingress plus instruction-memory write port of imem_loader.
// Latency : n/a (signal bundle only).
// Backpressure: byte_in/byte_valid transfer only when byte_ready is high.
//
// Signals:
//   byte_in    [7:0]        stream byte           (source -> loader)
//   byte_valid              byte_in valid         (source -> loader)
//   byte_ready              loader accepts byte   (loader -> source)
//   wr_en                   imem write strobe     (loader -> memory)
//   wr_addr    [ADDR_W-1:0] word-aligned byte addr (loader -> memory)
//   wr_data    [31:0]       word to write         (loader -> memory)
// Modports: master = stream source / memory side, slave = loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Purpose : boot loader; assembles a framed byte stream into big-endian words,
//           writes them to instruction memory from address 0, verifies an XOR checksum.
// Latency : a word's write strobe appears the cycle after its 4th byte is accepted.
// Backpressure: byte_ready is high in HEADER/DATA/CSUM, low in DONE/ERR.
//
// Ports:
//   clk       system clock, all state on rising edge
//   reset     asynchronous, active-low reset
//   bus       imem_loader_if.slave: byte stream in, imem write port out
//   reload    one-cycle pulse, restarts a load from DONE or ERR
//   cpu_hold  1 = keep the core in reset
//   done      load finished with good checksum
//   error     load aborted (oversized header or bad checksum)
//
// Frame: header N (0 means MAX_WORDS), 4*N data bytes MSB first, checksum byte
// equal to the XOR of the header and all data bytes.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    input  logic         reload,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    // Word index width: MAX_WORDS = 2^ADDR_W / 4 words fit in ADDR_W-2 bits.
    localparam int IDX_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_HEADER,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] word_idx;   // index of the word currently being assembled
    logic [IDX_W-1:0] last_idx;   // index of the final word of this frame
    logic [1:0]       byte_cnt;   // byte position inside the current word
    logic [7:0]       csum;       // running XOR of header and data bytes
    logic [23:0]      word_asm;   // first three bytes of the word in flight

    logic             xfer;
    logic             hdr_over;
    logic [IDX_W-1:0] hdr_last_idx;

    assign xfer = bus.byte_valid && bus.byte_ready;

    // Header decode. Storing N-1 rather than N lets a zero header mean a full
    // memory load without needing an extra bit to represent MAX_WORDS.
    always_comb begin
        hdr_over     = int'(bus.byte_in) > MAX_WORDS;
        hdr_last_idx = IDX_W'(MAX_WORDS - 1);
        if (bus.byte_in != 8'd0) begin
            hdr_last_idx = IDX_W'(bus.byte_in - 8'd1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_HEADER;
            bus.byte_ready <= 1'b1;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            word_idx       <= '0;
            last_idx       <= '0;
            byte_cnt       <= '0;
            csum           <= '0;
            word_asm       <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            bus.wr_en <= 1'b0;

            case (state)
                S_HEADER: begin
                    if (xfer) begin
                        csum <= bus.byte_in;
                        if (hdr_over) begin
                            state          <= S_ERR;
                            bus.byte_ready <= 1'b0;
                            error          <= 1'b1;
                        end else begin
                            last_idx <= hdr_last_idx;
                            state    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ bus.byte_in;
                        word_asm <= {word_asm[15:0], bus.byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Address uses the pre-increment index, so bumping
                            // the index on this same edge is equivalent to
                            // incrementing it after the write cycle.
                            bus.wr_en   <= 1'b1;
                            bus.wr_data <= {word_asm, bus.byte_in};
                            bus.wr_addr <= {word_idx, 2'b00};
                            word_idx    <= word_idx + IDX_W'(1);
                            if (word_idx == last_idx) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end

                S_CSUM: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_in == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end

                S_DONE, S_ERR: begin
                    // wr_addr/wr_data keep the last write for observability.
                    if (reload) begin
                        state          <= S_HEADER;
                        bus.byte_ready <= 1'b1;
                        cpu_hold       <= 1'b1;
                        done           <= 1'b0;
                        error          <= 1'b0;
                        word_idx       <= '0;
                        byte_cnt       <= '0;
                        csum           <= '0;
                        word_asm       <= '0;
                    end
                end

                default: begin
                    state <= S_HEADER;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : directed self-checking bench for imem_loader.
// Latency : n/a.
// Backpressure: stimulus waits (bounded) for byte_ready before each byte.
module tb_imem_loader;

    logic clk;
    logic reset;
    logic reload;
    logic cpu_hold;
    logic done;
    logic error;

    int errs;
    int checks;

    logic [7:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .reload   (reload),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture every write pulse mid-cycle; each pulse spans one negedge.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present one byte and hold it until a bounded wait sees it accepted.
    // Returns #1 after the accepting edge with byte_valid still high.
    task automatic send_byte(input logic [7:0] b);
        int accepted;
        accepted = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 50 && accepted == 0; i++) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accepted = 1;
            end
        end
        check("byte_accept", accepted, 1);
    endtask

    task automatic idle_cycles(input int n);
        bus.byte_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, bus.byte_ready, 1);
        check({tag, "_wr_en"}, bus.wr_en, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_wr_data"}, bus.wr_data, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
    endtask

    logic [7:0] frame1[6];
    logic [7:0] frame2[10];

    initial begin
        errs           = 0;
        checks         = 0;
        reset          = 1'b0;
        reload         = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;

        frame1 = '{8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
        // 02^11^22^33^44^DE^AD^BE^EF = 0x64
        frame2 = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h64};

        // ---- reset state ----
        #12;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(2);
        check_reset_values("post_rst");

        // ---- N=1, good checksum ----
        clear_log();
        foreach (frame1[i]) send_byte(frame1[i]);
        bus.byte_valid = 1'b0;
        check("n1_done", done, 1);
        check("n1_hold", cpu_hold, 0);
        check("n1_ready", bus.byte_ready, 0);
        check("n1_error", error, 0);
        check("n1_nwr", wq_addr.size(), 1);
        if (wq_addr.size() >= 1) begin
            check("n1_addr", wq_addr[0], 32'h00);
            check("n1_data", wq_data[0], 32'h20080005);
        end
        idle_cycles(3);
        check("n1_hold_data", bus.wr_data, 32'h20080005);
        check("n1_nwr_later", wq_addr.size(), 1);

        // ---- reload, N=2 with byte_valid toggling ----
        pulse_reload();
        check("rl_ready", bus.byte_ready, 1);
        check("rl_done", done, 0);
        check("rl_hold", cpu_hold, 1);
        clear_log();
        foreach (frame2[i]) begin
            send_byte(frame2[i]);
            idle_cycles(1);
        end
        idle_cycles(2);
        check("n2_done", done, 1);
        check("n2_hold", cpu_hold, 0);
        check("n2_nwr", wq_addr.size(), 2);
        if (wq_addr.size() >= 2) begin
            check("n2_addr0", wq_addr[0], 32'h00);
            check("n2_data0", wq_data[0], 32'h11223344);
            check("n2_addr1", wq_addr[1], 32'h04);
            check("n2_data1", wq_data[1], 32'hDEADBEEF);
        end

        // ---- oversized header ----
        pulse_reload();
        clear_log();
        send_byte(8'h41);
        bus.byte_valid = 1'b0;
        check("big_error", error, 1);
        check("big_hold", cpu_hold, 1);
        check("big_done", done, 0);
        check("big_ready", bus.byte_ready, 0);
        idle_cycles(4);
        check("big_nwr", wq_addr.size(), 0);

        // ---- N=1, bad checksum, then reload ----
        pulse_reload();
        clear_log();
        for (int i = 0; i < 5; i++) send_byte(frame1[i]);
        send_byte(8'h2D);
        bus.byte_valid = 1'b0;
        check("bad_error", error, 1);
        check("bad_done", done, 0);
        check("bad_hold", cpu_hold, 1);
        check("bad_nwr", wq_addr.size(), 1);
        if (wq_addr.size() >= 1) begin
            check("bad_addr", wq_addr[0], 32'h00);
            check("bad_data", wq_data[0], 32'h20080005);
        end
        idle_cycles(2);
        pulse_reload();
        check("bad_rl_error", error, 0);
        check("bad_rl_ready", bus.byte_ready, 1);
        check("bad_rl_hold", cpu_hold, 1);

        // ---- N=0 full load, continuous valid; XOR of 0..255 and header is 0 ----
        clear_log();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_byte(i[7:0]);
        send_byte(8'h00);
        bus.byte_valid = 1'b0;
        check("full_done", done, 1);
        check("full_hold", cpu_hold, 0);
        check("full_nwr", wq_addr.size(), 64);
        if (wq_addr.size() == 64) begin
            for (int k = 0; k < 64; k++) begin
                logic [7:0] b0;
                b0 = 8'(4 * k);
                check("full_addr", wq_addr[k], 32'(b0));
                check("full_data", wq_data[k], {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
            end
            check("full_last_addr", wq_addr[63], 32'hFC);
        end

        // ---- async reset mid-load, then fresh N=1 load ----
        pulse_reload();
        clear_log();
        for (int i = 0; i < 7; i++) send_byte(frame2[i]);
        bus.byte_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(1);
        clear_log();
        foreach (frame1[i]) send_byte(frame1[i]);
        bus.byte_valid = 1'b0;
        check("after_rst_done", done, 1);
        check("after_rst_nwr", wq_addr.size(), 1);
        if (wq_addr.size() >= 1) begin
            check("after_rst_addr", wq_addr[0], 32'h00);
            check("after_rst_data", wq_data[0], 32'h20080005);
        end

        idle_cycles(2);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
